// File: rtl/ysyx_25040109_gpr_csr_file.sv
// GPR file with bypassed combinational read ports, plus the M-mode CSR file
// with trap entry/MRET sequencing and 64-bit mcycle/minstret counters.
module ysyx_25040109_gpr_csr_file #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NREAD      = 2,
    parameter int BYPASS     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREAD*ADDR_WIDTH-1:0]   raddr,
    output logic [NREAD*DATA_WIDTH-1:0]   rdata,
    input  logic                          wen,
    input  logic [ADDR_WIDTH-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         a0_out,
    input  logic [11:0]                   csr_addr,
    input  logic                          csr_we,
    input  logic [DATA_WIDTH-1:0]         csr_wdata,
    output logic [DATA_WIDTH-1:0]         csr_rdata,
    output logic                          csr_illegal,
    input  logic                          trap_valid,
    input  logic [DATA_WIDTH-1:0]         trap_cause,
    input  logic [DATA_WIDTH-1:0]         trap_pc,
    input  logic                          mret_valid,
    input  logic                          instret,
    output logic [DATA_WIDTH-1:0]         mtvec_out,
    output logic [DATA_WIDTH-1:0]         mepc_out
);

    localparam int NREG = 1 << ADDR_WIDTH;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    logic [DATA_WIDTH-1:0] rf [NREG];

    logic                  mie;
    logic                  mpie;
    logic [DATA_WIDTH-1:0] mtvec;
    logic [DATA_WIDTH-1:0] mepc;
    logic [DATA_WIDTH-1:0] mcause;
    logic [DATA_WIDTH-1:0] mscratch;
    logic [63:0]           mcycle;
    logic [63:0]           minstret;

    logic                  csr_impl;
    logic                  csr_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            rf[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign rdata[k*DATA_WIDTH +: DATA_WIDTH] =
            (ra == '0)                               ? '0    :
            ((BYPASS != 0) && wen && (waddr == ra))  ? wdata :
                                                       rf[ra];
    end

    assign a0_out    = rf[10];
    assign mtvec_out = mtvec;
    assign mepc_out  = mepc;

    always_comb begin
        csr_impl  = 1'b1;
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS:   csr_rdata = DATA_WIDTH'({2'b11, 3'b000, mpie, 3'b000, mie, 3'b000});
            CSR_MTVEC:     csr_rdata = mtvec;
            CSR_MSCRATCH:  csr_rdata = mscratch;
            CSR_MEPC:      csr_rdata = mepc;
            CSR_MCAUSE:    csr_rdata = mcause;
            CSR_MCYCLE:    csr_rdata = DATA_WIDTH'(mcycle[31:0]);
            CSR_MCYCLEH:   csr_rdata = DATA_WIDTH'(mcycle[63:32]);
            CSR_MINSTRET:  csr_rdata = DATA_WIDTH'(minstret[31:0]);
            CSR_MINSTRETH: csr_rdata = DATA_WIDTH'(minstret[63:32]);
            CSR_MVENDORID: csr_rdata = DATA_WIDTH'(32'h7973_7978);
            CSR_MARCHID:   csr_rdata = DATA_WIDTH'(32'h017E_4A2D);
            default:       csr_impl  = 1'b0;
        endcase
    end

    // Address bits [11:10] == 2'b11 mark the read-only CSR space.
    assign csr_illegal = !csr_impl || (csr_we && (csr_addr[11:10] == 2'b11));
    assign csr_wr      = csr_we && !csr_illegal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mscratch <= '0;
        end else begin
            // A trap owns mstatus/mepc/mcause this cycle; MRET owns mstatus.
            if (trap_valid) begin
                mepc   <= trap_pc & ALIGN_MASK;
                mcause <= trap_cause;
                mpie   <= mie;
                mie    <= 1'b0;
            end else begin
                if (mret_valid) begin
                    mie  <= mpie;
                    mpie <= 1'b1;
                end else if (csr_wr && (csr_addr == CSR_MSTATUS)) begin
                    mie  <= csr_wdata[3];
                    mpie <= csr_wdata[7];
                end
                if (csr_wr && (csr_addr == CSR_MEPC)) begin
                    mepc <= csr_wdata & ALIGN_MASK;
                end
                if (csr_wr && (csr_addr == CSR_MCAUSE)) begin
                    mcause <= csr_wdata;
                end
            end
            if (csr_wr && (csr_addr == CSR_MTVEC)) begin
                mtvec <= csr_wdata & ALIGN_MASK;
            end
            if (csr_wr && (csr_addr == CSR_MSCRATCH)) begin
                mscratch <= csr_wdata;
            end
        end
    end

    // A write to either counter half replaces that cycle's increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (csr_wr && (csr_addr == CSR_MCYCLE)) begin
                mcycle <= {mcycle[63:32], csr_wdata[31:0]};
            end else if (csr_wr && (csr_addr == CSR_MCYCLEH)) begin
                mcycle <= {csr_wdata[31:0], mcycle[31:0]};
            end else begin
                mcycle <= mcycle + 64'd1;
            end

            if (csr_wr && (csr_addr == CSR_MINSTRET)) begin
                minstret <= {minstret[63:32], csr_wdata[31:0]};
            end else if (csr_wr && (csr_addr == CSR_MINSTRETH)) begin
                minstret <= {csr_wdata[31:0], minstret[31:0]};
            end else if (instret) begin
                minstret <= minstret + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040109_gpr_csr_file.sv
// Randomized and directed bench for ysyx_25040109_gpr_csr_file against a
// behavioural model of the register file, CSRs, traps and counters.
module tb_ysyx_25040109_gpr_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] a0_out;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret_valid;
    logic        instret;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_rf [32];
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mscratch;
    logic [63:0] m_cyc, m_ins;

    always #5 clk = ~clk;

    ysyx_25040109_gpr_csr_file dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata),
        .wen(wen), .waddr(waddr), .wdata(wdata), .a0_out(a0_out),
        .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret_valid(mret_valid), .instret(instret),
        .mtvec_out(mtvec_out), .mepc_out(mepc_out)
    );

    function automatic bit exp_impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
            12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] exp_csr(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            12'hF11: return 32'h79737978;
            12'hF12: return 32'h017E4A2D;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_mie = 1'b0; m_mpie = 1'b0;
        m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mscratch = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    task automatic idle();
        wen = 0; waddr = 0; wdata = 0;
        csr_we = 0; csr_wdata = 0;
        trap_valid = 0; trap_cause = 0; trap_pc = 0;
        mret_valid = 0; instret = 0;
    endtask

    // One clock edge: capture inputs, advance the model by the architectural rules.
    task automatic tick();
        bit gw, wr, tv, mv, ir;
        logic [4:0]  ga;
        logic [31:0] gd, d, tc, tp;
        logic [11:0] a;
        gw = wen; ga = waddr; gd = wdata;
        a = csr_addr; d = csr_wdata;
        wr = csr_we && exp_impl(a) && (a[11:10] != 2'b11);
        tv = trap_valid; mv = mret_valid; ir = instret;
        tc = trap_cause; tp = trap_pc;
        @(posedge clk);
        if (gw && ga != 0) m_rf[ga] = gd;
        if (tv) begin
            m_mepc = tp & ~32'h3; m_mcause = tc;
            m_mpie = m_mie; m_mie = 1'b0;
        end else begin
            if (mv) begin
                m_mie = m_mpie; m_mpie = 1'b1;
            end else if (wr && a == 12'h300) begin
                m_mie = d[3]; m_mpie = d[7];
            end
            if (wr && a == 12'h341) m_mepc = d & ~32'h3;
            if (wr && a == 12'h342) m_mcause = d;
        end
        if (wr && a == 12'h305) m_mtvec = d & ~32'h3;
        if (wr && a == 12'h340) m_mscratch = d;
        if (wr && a == 12'hB00)      m_cyc = {m_cyc[63:32], d};
        else if (wr && a == 12'hB80) m_cyc = {d, m_cyc[31:0]};
        else                         m_cyc = m_cyc + 1;
        if (wr && a == 12'hB02)      m_ins = {m_ins[63:32], d};
        else if (wr && a == 12'hB82) m_ins = {d, m_ins[31:0]};
        else if (ir)                 m_ins = m_ins + 1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; idle(); csr_addr = 12'h300; raddr = {5'd10, 5'd3};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (a0_out !== 32'h0) begin errors++; $display("FAIL reset_a0 got=%h exp=0", a0_out); end
        checks++; if (mtvec_out !== 32'h0 || mepc_out !== 32'h0) begin
            errors++; $display("FAIL reset_mtvec_mepc got=%h/%h exp=0/0", mtvec_out, mepc_out); end
        #1;
        checks++; if (csr_rdata !== 32'h1800) begin errors++; $display("FAIL reset_mstatus got=%h exp=00001800", csr_rdata); end
        csr_addr = 12'hB00; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL reset_mcycle got=%h exp=0", csr_rdata); end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        m_cyc = 1;
        checks++; if (csr_rdata !== 32'h1) begin errors++; $display("FAIL first_count got=%h exp=1", csr_rdata); end
    endtask

    task automatic test_bypass();
        idle();
        wen = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr = {5'd0, 5'd5}; #1;
        checks++; if (rdata[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd0 got=%h exp=deadbeef", rdata[31:0]); end
        checks++; if (rdata[63:32] !== 32'h0) begin errors++; $display("FAIL bypass_x0_port got=%h exp=0", rdata[63:32]); end
        tick(); idle(); #1;
        checks++; if (rdata[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL reg_rd0 got=%h exp=deadbeef", rdata[31:0]); end
        wen = 1; waddr = 0; wdata = 32'hFFFFFFFF; raddr = {5'd5, 5'd0}; #1;
        checks++; if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL x0_bypass got=%h exp=0", rdata[31:0]); end
        tick(); idle(); #1;
        checks++; if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL x0_write got=%h exp=0", rdata[31:0]); end
        wen = 1; waddr = 10; wdata = 32'h12345678; #1;
        checks++; if (a0_out !== 32'h0) begin errors++; $display("FAIL a0_no_bypass got=%h exp=0", a0_out); end
        tick(); idle(); #1;
        checks++; if (a0_out !== 32'h12345678) begin errors++; $display("FAIL a0_write got=%h exp=12345678", a0_out); end
    endtask

    task automatic test_gpr_random();
        logic [4:0]  ra0, ra1;
        logic [31:0] e0, e1;
        for (int i = 0; i < 60; i++) begin
            idle();
            wen = 1'($urandom); waddr = 5'($urandom); wdata = $urandom;
            ra0 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            ra1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
            raddr = {ra1, ra0}; #1;
            e0 = (ra0 == 0) ? 32'h0 : (wen && waddr == ra0) ? wdata : m_rf[ra0];
            e1 = (ra1 == 0) ? 32'h0 : (wen && waddr == ra1) ? wdata : m_rf[ra1];
            checks++; if (rdata[31:0] !== e0) begin errors++; $display("FAIL gpr_rd0[%0d] x%0d got=%h exp=%h", i, ra0, rdata[31:0], e0); end
            checks++; if (rdata[63:32] !== e1) begin errors++; $display("FAIL gpr_rd1[%0d] x%0d got=%h exp=%h", i, ra1, rdata[63:32], e1); end
            checks++; if (a0_out !== m_rf[10]) begin errors++; $display("FAIL gpr_a0[%0d] got=%h exp=%h", i, a0_out, m_rf[10]); end
            tick();
        end
    endtask

    task automatic test_csr_random();
        logic [11:0] tbl [12];
        logic [31:0] e;
        bit          ill;
        tbl = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12, 12'h7C0};
        for (int i = 0; i < 100; i++) begin
            idle();
            csr_addr   = ($urandom_range(0, 7) == 0) ? 12'($urandom) : tbl[$urandom_range(0, 11)];
            csr_we     = 1'($urandom);
            csr_wdata  = $urandom;
            trap_valid = ($urandom_range(0, 7) == 0);
            mret_valid = ($urandom_range(0, 7) == 0);
            trap_pc    = $urandom; trap_cause = $urandom;
            instret    = 1'($urandom);
            #1;
            e   = exp_csr(csr_addr);
            ill = !exp_impl(csr_addr) || (csr_we && csr_addr[11:10] == 2'b11);
            checks++; if (csr_rdata !== e) begin errors++; $display("FAIL csr_rd[%0d] addr=%h got=%h exp=%h", i, csr_addr, csr_rdata, e); end
            checks++; if (csr_illegal !== ill) begin errors++; $display("FAIL csr_ill[%0d] addr=%h got=%b exp=%b", i, csr_addr, csr_illegal, ill); end
            tick();
            checks++; if (mtvec_out !== m_mtvec || mepc_out !== m_mepc) begin
                errors++; $display("FAIL csr_outs[%0d] got=%h/%h exp=%h/%h", i, mtvec_out, mepc_out, m_mtvec, m_mepc); end
        end
    endtask

    task automatic test_trap_mret();
        idle(); csr_addr = 12'h300; csr_we = 1; csr_wdata = 32'h8; tick();
        idle(); #1;
        checks++; if (csr_rdata !== 32'h1808) begin errors++; $display("FAIL set_mie got=%h exp=00001808", csr_rdata); end
        trap_valid = 1; trap_pc = 32'h80000107; trap_cause = 32'd11; #1;
        checks++; if (csr_rdata !== 32'h1808) begin errors++; $display("FAIL pretrap_read got=%h exp=00001808", csr_rdata); end
        tick(); idle(); #1;
        checks++; if (mepc_out !== 32'h80000104) begin errors++; $display("FAIL trap_mepc got=%h exp=80000104", mepc_out); end
        checks++; if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL trap_mstatus got=%h exp=00001880", csr_rdata); end
        csr_addr = 12'h342; #1;
        checks++; if (csr_rdata !== 32'd11) begin errors++; $display("FAIL trap_mcause got=%h exp=0000000b", csr_rdata); end
        csr_addr = 12'h300; mret_valid = 1; tick(); idle(); #1;
        checks++; if (csr_rdata !== 32'h1888) begin errors++; $display("FAIL mret_mstatus got=%h exp=00001888", csr_rdata); end
    endtask

    task automatic test_priority();
        idle(); trap_valid = 1; trap_pc = 32'h40; trap_cause = 32'd2;
        csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h1234; tick(); idle(); #1;
        checks++; if (mepc_out !== 32'h40) begin errors++; $display("FAIL prio_mepc got=%h exp=00000040", mepc_out); end
        trap_valid = 1; trap_pc = 32'h80; csr_we = 1; csr_addr = 12'h340; csr_wdata = 32'h55;
        tick(); idle(); #1;
        checks++; if (csr_rdata !== 32'h55) begin errors++; $display("FAIL prio_mscratch got=%h exp=00000055", csr_rdata); end
        csr_addr = 12'h300; csr_we = 1; csr_wdata = 32'h88; tick();
        idle(); trap_valid = 1; mret_valid = 1; trap_pc = 32'h100; tick(); idle(); #1;
        checks++; if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL prio_trap_mret got=%h exp=00001880", csr_rdata); end
    endtask

    task automatic test_counters();
        logic [31:0] exp_lo [4];
        logic [31:0] exp_hi [4];
        bit          pat [4];
        idle(); csr_addr = 12'hB80; csr_we = 1; csr_wdata = 0; tick();
        csr_addr = 12'hB00; csr_wdata = 32'hFFFFFFFF; tick(); idle(); #1;
        checks++; if (csr_rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL mcycle_load got=%h exp=ffffffff", csr_rdata); end
        csr_addr = 12'hB80; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mcycleh_load got=%h exp=0", csr_rdata); end
        tick(); csr_addr = 12'hB00; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mcycle_wrap got=%h exp=0", csr_rdata); end
        csr_addr = 12'hB80; #1;
        checks++; if (csr_rdata !== 32'h1) begin errors++; $display("FAIL mcycleh_carry got=%h exp=1", csr_rdata); end
        csr_addr = 12'hB82; csr_we = 1; csr_wdata = 0; tick();
        csr_addr = 12'hB02; csr_wdata = 32'hFFFFFFFE; tick(); idle();
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_lo = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1};
        exp_hi = '{32'h0, 32'h0, 32'h1, 32'h1};
        for (int i = 0; i < 4; i++) begin
            instret = pat[i]; tick(); instret = 0;
            csr_addr = 12'hB02; #1;
            checks++; if (csr_rdata !== exp_lo[i]) begin errors++; $display("FAIL minstret[%0d] got=%h exp=%h", i, csr_rdata, exp_lo[i]); end
            csr_addr = 12'hB82; #1;
            checks++; if (csr_rdata !== exp_hi[i]) begin errors++; $display("FAIL minstreth[%0d] got=%h exp=%h", i, csr_rdata, exp_hi[i]); end
        end
    endtask

    task automatic test_illegal();
        idle(); csr_addr = 12'h7C0; #1;
        checks++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin
            errors++; $display("FAIL ill_unimpl got=%b/%h exp=1/0", csr_illegal, csr_rdata); end
        csr_addr = 12'hF11; csr_we = 1; csr_wdata = 32'h0; #1;
        checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL ill_ro_write got=%b exp=1", csr_illegal); end
        tick(); idle(); #1;
        checks++; if (csr_illegal !== 1'b0 || csr_rdata !== 32'h79737978) begin
            errors++; $display("FAIL mvendorid got=%b/%h exp=0/79737978", csr_illegal, csr_rdata); end
        csr_addr = 12'hF12; #1;
        checks++; if (csr_rdata !== 32'h017E4A2D) begin errors++; $display("FAIL marchid got=%h exp=017e4a2d", csr_rdata); end
    endtask

    task automatic test_async_reset();
        idle(); csr_addr = 12'h305; csr_we = 1; csr_wdata = 32'h80000003;
        wen = 1; waddr = 10; wdata = 32'hA5A5A5A5; tick(); idle(); #1;
        checks++; if (mtvec_out !== 32'h80000000) begin errors++; $display("FAIL mtvec_align got=%h exp=80000000", mtvec_out); end
        raddr = {5'd10, 5'd10};
        #1 rst = 1'b0;
        #1;
        checks++; if (a0_out !== 32'h0 || rdata !== 64'h0) begin
            errors++; $display("FAIL async_gpr got=%h/%h exp=0/0", a0_out, rdata); end
        checks++; if (mtvec_out !== 32'h0 || mepc_out !== 32'h0) begin
            errors++; $display("FAIL async_csr got=%h/%h exp=0/0", mtvec_out, mepc_out); end
        csr_addr = 12'h300; #1;
        checks++; if (csr_rdata !== 32'h1800) begin errors++; $display("FAIL async_mstatus got=%h exp=00001800", csr_rdata); end
        csr_addr = 12'hB00; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL async_mcycle got=%h exp=0", csr_rdata); end
        #1 rst = 1'b1;
        model_reset();
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (csr_rdata !== m_cyc[31:0]) begin
                errors++; $display("FAIL restart_mcycle[%0d] got=%h exp=%h", i, csr_rdata, m_cyc[31:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_gpr_random();
        test_csr_random();
        test_trap_mret();
        test_priority();
        test_counters();
        test_illegal();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
